// File: rtl/lfsr_updn_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_updn_checker_if
//  Description : Monitor bus between an up/down LFSR counter stage and its
//                sequence checker. The master side carries the counter's
//                controls and outputs; the slave side is the checker.
//                Optional macro LFSR_CHK_CAPTURE_EN adds err_exp/err_act.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_updn_checker_if #(
    parameter int WIDTH  = 8,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    // Counter controls and outputs, observed by the checker
    logic              updn;
    logic              cen;
    logic [WIDTH-1:0]  count;
    logic              tercnt;
    logic              clr;

    // Checker status
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

`ifdef LFSR_CHK_CAPTURE_EN
    logic [WIDTH-1:0]  err_exp;
    logic [WIDTH-1:0]  err_act;

    modport master (
        output updn, cen, count, tercnt, clr,
        input  locked, err_pulse, err_cnt, wrap_cnt, err_exp, err_act
    );

    modport slave (
        input  updn, cen, count, tercnt, clr,
        output locked, err_pulse, err_cnt, wrap_cnt, err_exp, err_act
    );
`else
    modport master (
        output updn, cen, count, tercnt, clr,
        input  locked, err_pulse, err_cnt, wrap_cnt
    );

    modport slave (
        input  updn, cen, count, tercnt, clr,
        output locked, err_pulse, err_cnt, wrap_cnt
    );
`endif

endinterface
`default_nettype wire

// File: rtl/lfsr_updn_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_updn_checker
//  Description : Passive monitor for an up/down LFSR counter. Registers the
//                observed count and controls, predicts the next count and
//                tracks lock; while locked each misprediction raises a
//                one-cycle err_pulse and bumps a saturating error counter.
//                Terminal-count events (tercnt && cen) are counted with wrap.
//                Optional macro LFSR_CHK_CAPTURE_EN adds err_exp/err_act,
//                which hold the first locked mismatch since reset/clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_updn_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int               LOCK_CNT = 4,
    parameter int               ERR_W    = 8,
    parameter int               WRAP_W   = 16
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    lfsr_updn_checker_if.slave  mon_if
);

    // run_q only needs to reach LOCK_CNT, which is limited to 15
    localparam int               RUN_W      = 4;
    localparam logic [RUN_W-1:0] c_lock_cnt = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Forward step: shift left, XNOR feedback into bit 0
    function automatic logic [WIDTH-1:0] f_up(input logic [WIDTH-1:0] c);
        f_up = {c[WIDTH-2:0], ~^(c & TAPS)};
    endfunction

    // Reverse step: recovers the bit shifted out by f_up (TAPS MSB is 1)
    function automatic logic [WIDTH-1:0] f_down(input logic [WIDTH-1:0] c);
        f_down = {~c[0] ^ (^(c[WIDTH-1:1] & TAPS[WIDTH-2:0])), c[WIDTH-1:1]};
    endfunction

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]  prev_cnt_q;
    logic              prev_updn_q;
    logic              prev_cen_q;

    logic [WIDTH-1:0]  exp_cnt;
    logic              match;
    logic              lock_miss;

    assign exp_cnt   = prev_cen_q ? (prev_updn_q ? f_up(prev_cnt_q) : f_down(prev_cnt_q))
                                  : prev_cnt_q;
    assign match     = (mon_if.count == exp_cnt);
    // A mismatch that actually counts as an error; clr suppresses it
    assign lock_miss = (state_q == S_LOCKED) && !match && !mon_if.clr;

    // Sample pipeline: always captures, clr does not stop it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_cnt_q  <= '0;
            prev_updn_q <= 1'b0;
            prev_cen_q  <= 1'b0;
        end else begin
            prev_cnt_q  <= mon_if.count;
            prev_updn_q <= mon_if.updn;
            prev_cen_q  <= mon_if.cen;
        end
    end

    // Lock-tracking state and status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            run_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    // Next-state logic: clr overrides everything, otherwise walk IDLE/CHECK/LOCKED
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q + WRAP_W'(mon_if.tercnt & mon_if.cen);

        if (mon_if.clr) begin
            state_d    = S_IDLE;
            run_d      = '0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // First sample after reset/clr has nothing to compare against
                    state_d = S_CHECK;
                    run_d   = '0;
                end
                S_CHECK: begin
                    if (match) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) == c_lock_cnt) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (!match) begin
                        // Resync: the mismatching sample becomes the new reference
                        err_pulse_d = 1'b1;
                        state_d     = S_CHECK;
                        run_d       = '0;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign mon_if.locked    = (state_q == S_LOCKED);
    assign mon_if.err_pulse = err_pulse_q;
    assign mon_if.err_cnt   = err_cnt_q;
    assign mon_if.wrap_cnt  = wrap_cnt_q;

`ifdef LFSR_CHK_CAPTURE_EN
    logic             cap_done_q;
    logic [WIDTH-1:0] err_exp_q;
    logic [WIDTH-1:0] err_act_q;

    // Freeze the first locked mismatch until the next reset/clr
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_done_q <= 1'b0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else if (mon_if.clr) begin
            cap_done_q <= 1'b0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else if (lock_miss && !cap_done_q) begin
            cap_done_q <= 1'b1;
            err_exp_q  <= exp_cnt;
            err_act_q  <= mon_if.count;
        end
    end

    assign mon_if.err_exp = err_exp_q;
    assign mon_if.err_act = err_act_q;
`else
    // No mismatch capture; lock_miss has no consumer in this build
    logic unused_lock_miss;
    assign unused_lock_miss = lock_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_updn_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_updn_checker
//  Description : Scoreboard bench for lfsr_updn_checker. A driver applies
//                directed and random samples, steps a behavioural model and
//                queues the expected status; a monitor pops and compares one
//                entry per clock. Honours LFSR_CHK_CAPTURE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_updn_checker;

    localparam int LOCK_CNT = 4;
    localparam int TAPS_I   = 'hB8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_updn_checker_if #(.WIDTH(8), .ERR_W(8), .WRAP_W(16)) bus ();

    lfsr_updn_checker #(
        .WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(LOCK_CNT), .ERR_W(8), .WRAP_W(16)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .mon_if (bus)
    );

    typedef struct {
        int lk;
        int pulse;
        int errs;
        int wraps;
        int eexp;
        int eact;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int m_active, m_lk, m_streak, m_errs, m_wraps, m_pulse;
    int m_prev, m_pupdn, m_pcen, m_cap, m_eexp, m_eact;

    function automatic int mdl_up(int c);
        return ((c << 1) & 255) | ((($countones(c & TAPS_I) % 2) == 0) ? 1 : 0);
    endfunction

    function automatic int mdl_down(int c);
        int b;
        b = (1 - (c & 1)) ^ ($countones((c >> 1) & (TAPS_I & 127)) % 2);
        return (c >> 1) | (b << 7);
    endfunction

    function automatic int mdl_next(int c, int u, int e);
        if (e == 0) return c;
        return (u != 0) ? mdl_up(c) : mdl_down(c);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_lk = 0; m_streak = 0; m_errs = 0; m_wraps = 0; m_pulse = 0;
        m_prev = 0; m_pupdn = 0; m_pcen = 0; m_cap = 0; m_eexp = 0; m_eact = 0;
    endtask

    task automatic model_step(input int u, input int c, input int cnt, input int t, input int cl);
        int e;
        m_pulse = 0;
        if (cl != 0) begin
            m_active = 0; m_lk = 0; m_streak = 0; m_errs = 0; m_wraps = 0;
            m_cap = 0; m_eexp = 0; m_eact = 0;
        end else begin
            if (t != 0 && c != 0) m_wraps = (m_wraps + 1) % 65536;
            if (m_active == 0) begin
                m_active = 1;
                m_streak = 0;
            end else begin
                e = mdl_next(m_prev, m_pupdn, m_pcen);
                if (cnt == e) begin
                    if (m_lk == 0) begin
                        m_streak++;
                        if (m_streak >= LOCK_CNT) m_lk = 1;
                    end
                end else begin
                    if (m_lk != 0) begin
                        m_pulse = 1;
                        if (m_errs < 255) m_errs++;
                        if (m_cap == 0) begin
                            m_cap = 1; m_eexp = e; m_eact = cnt;
                        end
                    end
                    m_lk = 0;
                    m_streak = 0;
                end
            end
        end
        m_prev = cnt; m_pupdn = u; m_pcen = c;
    endtask

    // Apply one sample, queue its expected outcome, advance to posedge+2
    task automatic drive(input int u, input int c, input int cnt, input int t, input int cl);
        exp_t x;
        bus.updn   = u[0];
        bus.cen    = c[0];
        bus.count  = cnt[7:0];
        bus.tercnt = t[0];
        bus.clr    = cl[0];
        model_step(u, c, cnt, t, cl);
        x.lk = m_lk; x.pulse = m_pulse; x.errs = m_errs; x.wraps = m_wraps;
        x.eexp = m_eexp; x.eact = m_eact;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("locked",    int'(bus.locked),    e.lk);
                chk("err_pulse", int'(bus.err_pulse), e.pulse);
                chk("err_cnt",   int'(bus.err_cnt),   e.errs);
                chk("wrap_cnt",  int'(bus.wrap_cnt),  e.wraps);
`ifdef LFSR_CHK_CAPTURE_EN
                chk("err_exp",   int'(bus.err_exp),   e.eexp);
                chk("err_act",   int'(bus.err_act),   e.eact);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur, u, v, w0, c, t, cl, cnt;
        model_reset();
        rst = 1'b1;
        bus.updn = 1'b0; bus.cen = 1'b0; bus.count = 8'h00; bus.tercnt = 1'b0; bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_locked",    int'(bus.locked),    0);
        chk("rst_err_pulse", int'(bus.err_pulse), 0);
        chk("rst_err_cnt",   int'(bus.err_cnt),   0);
        chk("rst_wrap_cnt",  int'(bus.wrap_cnt),  0);
        rst = 1'b0;

        // Up-sequence from 0 locks
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, cur, 0, 0);
            cur = mdl_up(cur);
        end
        chk("t1_locked",  int'(bus.locked),  1);
        chk("t1_err_cnt", int'(bus.err_cnt), 0);

        // Single corrupted sample while locked
        drive(1, 1, 'h5A, 0, 0);
        chk("t2_pulse",   int'(bus.err_pulse), 1);
        chk("t2_err_cnt", int'(bus.err_cnt),   1);
        chk("t2_locked",  int'(bus.locked),    0);
        cur = mdl_up('h5A);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, cur, 0, 0);
            cur = mdl_up(cur);
        end
        chk("t2_relock", int'(bus.locked), 1);

        // Up then down then up around every state of the cycle
        for (int i = 0; i < 255; i++) begin
            u = mdl_up(cur);
            drive(1, 1, cur, 0, 0);
            drive(0, 1, u,   0, 0);
            drive(1, 1, cur, 0, 0);
            cur = u;
        end
        chk("t3_err_cnt", int'(bus.err_cnt), 1);
        chk("t3_locked",  int'(bus.locked),  1);
        // All-ones is a fixed point in both directions
        for (int i = 0; i < 4; i++) drive(1, 1, 'hFF, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 'hFF, 0, 0);
        cur = 'hFF;

        // Hold with cen=0; tercnt toggling must not count
        w0 = m_wraps;
        for (int i = 0; i < 10; i++) drive(int'($urandom_range(0, 1)), 0, cur, i % 2, 0);
        chk("t4_locked",   int'(bus.locked),   1);
        chk("t4_wrap_cnt", int'(bus.wrap_cnt), w0);
        for (int i = 0; i < 3; i++) drive(1, 1, cur, 1, 0);
        chk("t4_wrap_inc", int'(bus.wrap_cnt), w0 + 3);

        // 300 locked mismatches saturate the error counter
        v = cur;
        for (int k = 0; k < 300; k++) begin
            v = (v + 1 + int'($urandom_range(0, 254))) % 256;
            for (int j = 0; j < 5; j++) drive(int'($urandom_range(0, 1)), 0, v, int'($urandom_range(0, 1)), 0);
        end
        chk("t5_err_sat", int'(bus.err_cnt), 255);
        chk("t5_locked",  int'(bus.locked),  1);
        drive(0, 0, v ^ 1, 0, 1);
        chk("t5_clr_err_cnt", int'(bus.err_cnt),   0);
        chk("t5_clr_pulse",   int'(bus.err_pulse), 0);
        chk("t5_clr_locked",  int'(bus.locked),    0);
        chk("t5_clr_wrap",    int'(bus.wrap_cnt),  0);

        // Two locked errors: the first one is captured
        for (int i = 0; i < 6; i++) drive(0, 0, 'h03, 0, 0);
        drive(0, 0, 'h07, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 'h07, 0, 0);
        drive(0, 0, 'h09, 0, 0);
        chk("t6_err_cnt", int'(bus.err_cnt), 2);
`ifdef LFSR_CHK_CAPTURE_EN
        chk("t6_err_exp", int'(bus.err_exp), 'h03);
        chk("t6_err_act", int'(bus.err_act), 'h07);
`endif
        cur = 'h09;

        // Random controls with occasional corruption and clr
        for (int i = 0; i < 1500; i++) begin
            u  = int'($urandom_range(0, 1));
            c  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            t  = int'($urandom_range(0, 1));
            cl = ($urandom_range(0, 99) == 0) ? 1 : 0;
            cnt = ($urandom_range(0, 99) < 3) ? int'($urandom_range(0, 255)) : cur;
            drive(u, c, cnt, t, cl);
            cur = mdl_next(cnt, u, c);
        end

        // Asynchronous reset between edges
        rst = 1'b1;
        #1;
        chk("t7_arst_locked",  int'(bus.locked),    0);
        chk("t7_arst_pulse",   int'(bus.err_pulse), 0);
        chk("t7_arst_err_cnt", int'(bus.err_cnt),   0);
        chk("t7_arst_wrap",    int'(bus.wrap_cnt),  0);
`ifdef LFSR_CHK_CAPTURE_EN
        chk("t7_arst_err_exp", int'(bus.err_exp), 0);
        chk("t7_arst_err_act", int'(bus.err_act), 0);
`endif
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        cur = 'h2C;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, cur, 1, 0);
            cur = mdl_down(cur);
        end
        chk("t7_relock", int'(bus.locked), 1);

        @(posedge clk);
        #2;
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
